// File: rtl/fmult_arbiter_if.sv
// -----------------------------------------------------------------------------
// fmult_arbiter_if
// Bundles every non-clock signal of the two-requester fmult arbiter.
//   a0_* / a1_*      : requester operand pairs with valid/ready handshake
//   mul_*            : operands to, and result/flags from, the shared fmult
//   res_data, r*_valid : registered result and per-requester delivery pulse
//   stat0 / stat1    : sticky {nan, overflow, underflow, zero} per requester
//   stat_clr         : synchronous clear of both sticky registers
//   idle             : nothing in flight and nothing requested
// modport slave  : arbiter side
// modport master : requesters + fmult side (environment)
// -----------------------------------------------------------------------------
interface fmult_arbiter_if #(
  parameter int W = 32
);
  logic         a0_valid;
  logic         a0_ready;
  logic [W-1:0] a0_dataa;
  logic [W-1:0] a0_datab;
  logic         a1_valid;
  logic         a1_ready;
  logic [W-1:0] a1_dataa;
  logic [W-1:0] a1_datab;
  logic [W-1:0] mul_dataa;
  logic [W-1:0] mul_datab;
  logic [W-1:0] mul_result;
  logic         mul_nan;
  logic         mul_overflow;
  logic         mul_underflow;
  logic         mul_zero;
  logic [W-1:0] res_data;
  logic         r0_valid;
  logic         r1_valid;
  logic [3:0]   stat0;
  logic [3:0]   stat1;
  logic         stat_clr;
  logic         idle;

  modport slave (
    input  a0_valid, a0_dataa, a0_datab,
    input  a1_valid, a1_dataa, a1_datab,
    input  mul_result, mul_nan, mul_overflow, mul_underflow, mul_zero,
    input  stat_clr,
    output a0_ready, a1_ready,
    output mul_dataa, mul_datab,
    output res_data, r0_valid, r1_valid,
    output stat0, stat1, idle
  );

  modport master (
    output a0_valid, a0_dataa, a0_datab,
    output a1_valid, a1_dataa, a1_datab,
    output mul_result, mul_nan, mul_overflow, mul_underflow, mul_zero,
    output stat_clr,
    input  a0_ready, a1_ready,
    input  mul_dataa, mul_datab,
    input  res_data, r0_valid, r1_valid,
    input  stat0, stat1, idle
  );
endinterface

// File: rtl/fmult_arbiter.sv
// -----------------------------------------------------------------------------
// fmult_arbiter
// Shares one fixed-latency floating-point multiplier between two requesters.
// Round-robin grant (one pair per cycle), a tag pipeline that follows each
// pair through the multiplier, a registered result with a per-requester
// one-cycle valid pulse, and sticky per-requester exception flags.
// Ports:
//   clk      : clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : fmult_arbiter_if.slave (handshakes, fmult side, results, status)
// Parameters:
//   LAT : fmult pipeline latency in clocks (operand register to result valid)
//   W   : operand/result width
// -----------------------------------------------------------------------------
module fmult_arbiter #(
  parameter int LAT = 11,
  parameter int W   = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  fmult_arbiter_if.slave  bus
);

  // In-flight count can reach LAT+1 while streaming (an acceptance and a
  // delivery on the same edge leave it unchanged), so size for LAT+1.
  localparam int CW = $clog2(LAT + 2);

  logic           rr_reg;
  logic           rr_next;
  // Tag pipeline: one stage per clock between acceptance edge k and the
  // delivery edge k+LAT+1 (operand register plus LAT fmult stages).
  logic [LAT:0]   tag_valid_reg;
  logic [LAT:0]   tag_id_reg;
  logic [CW-1:0]  count_reg;
  logic [CW-1:0]  count_next;
  logic [W-1:0]   mul_dataa_reg;
  logic [W-1:0]   mul_datab_reg;
  logic [W-1:0]   res_data_reg;
  logic           r0_valid_reg;
  logic           r1_valid_reg;
  logic [3:0]     stat0_reg;
  logic [3:0]     stat1_reg;
  logic [3:0]     stat0_next;
  logic [3:0]     stat1_next;
  logic [3:0]     flags;

  logic           grant0;
  logic           grant1;
  logic           accept;
  logic           deliver;
  logic           deliver_id;

  // ---------------------------------------------------------------------------
  // Grant: a lone requester always wins; on contention rr_reg picks.
  // Gated by reset_n so no handshake completes while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant0  = reset_n & bus.a0_valid & (~bus.a1_valid | ~rr_reg);
    grant1  = reset_n & bus.a1_valid & (~bus.a0_valid |  rr_reg);
    accept  = grant0 | grant1;
    rr_next = rr_reg;
    if (accept) begin
      rr_next = grant0;  // point at the requester that was not served
    end
  end

  assign deliver    = tag_valid_reg[LAT];
  assign deliver_id = tag_id_reg[LAT];
  assign flags      = {bus.mul_nan, bus.mul_overflow, bus.mul_underflow, bus.mul_zero};

  // ---------------------------------------------------------------------------
  // In-flight counter and sticky status next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next = count_reg;
    if (accept && !deliver) begin
      count_next = count_reg + CW'(1);
    end else if (!accept && deliver) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Clear is applied first so that flags arriving on the same edge survive.
  always_comb begin
    stat0_next = bus.stat_clr ? 4'd0 : stat0_reg;
    stat1_next = bus.stat_clr ? 4'd0 : stat1_reg;
    if (deliver && !deliver_id) begin
      stat0_next = stat0_next | flags;
    end
    if (deliver && deliver_id) begin
      stat1_next = stat1_next | flags;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_reg        <= 1'b0;
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
      count_reg     <= '0;
    end else begin
      rr_reg        <= rr_next;
      tag_valid_reg <= {tag_valid_reg[LAT-1:0], accept};
      tag_id_reg    <= {tag_id_reg[LAT-1:0], grant1};
      count_reg     <= count_next;
    end
  end

  // Operands are held between acceptances; the fmult keeps recomputing the
  // same product, which is harmless because untagged results are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_dataa_reg <= '0;
      mul_datab_reg <= '0;
    end else if (accept) begin
      mul_dataa_reg <= grant0 ? bus.a0_dataa : bus.a1_dataa;
      mul_datab_reg <= grant0 ? bus.a0_datab : bus.a1_datab;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_data_reg <= '0;
      r0_valid_reg <= 1'b0;
      r1_valid_reg <= 1'b0;
      stat0_reg    <= 4'd0;
      stat1_reg    <= 4'd0;
    end else begin
      r0_valid_reg <= deliver & ~deliver_id;
      r1_valid_reg <= deliver &  deliver_id;
      if (deliver) begin
        res_data_reg <= bus.mul_result;
      end
      stat0_reg <= stat0_next;
      stat1_reg <= stat1_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.a0_ready  = grant0;
  assign bus.a1_ready  = grant1;
  assign bus.mul_dataa = mul_dataa_reg;
  assign bus.mul_datab = mul_datab_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.r0_valid  = r0_valid_reg;
  assign bus.r1_valid  = r1_valid_reg;
  assign bus.stat0     = stat0_reg;
  assign bus.stat1     = stat1_reg;
  assign bus.idle      = (count_reg == '0) && !bus.a0_valid && !bus.a1_valid;

endmodule

// File: tb/tb_fmult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fmult_arbiter
// Directed bench for fmult_arbiter. A small fmult stand-in (LAT-stage pipe)
// computes x*1.0 and x*2.0 exactly for the vectors used here; all expected
// results below are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fmult_arbiter;
  localparam int LAT = 11;
  localparam int W   = 32;

  localparam logic [31:0] F_0P5 = 32'h3F000000;
  localparam logic [31:0] F_1P0 = 32'h3F800000;
  localparam logic [31:0] F_1P5 = 32'h3FC00000;
  localparam logic [31:0] F_2P0 = 32'h40000000;
  localparam logic [31:0] F_3P0 = 32'h40400000;
  localparam logic [31:0] F_4P0 = 32'h40800000;
  localparam logic [31:0] F_6P0 = 32'h40C00000;
  localparam logic [31:0] F_8P0 = 32'h41000000;
  localparam logic [31:0] F_MAX = 32'h7F7FFFFF;
  localparam logic [31:0] F_INF = 32'h7F800000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fmult_arbiter_if #(.W(W)) bus ();

  fmult_arbiter #(.LAT(LAT), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // fmult stand-in: returns {nan, overflow, underflow, zero, result}
  function automatic logic [W+3:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] e;
    if (a == F_1P0) return {3'b000, (b[30:0] == 31'd0), b};
    if (b == F_2P0) begin
      e = a[30:23];
      if (e >= 8'd254) return {4'b0100, a[31], 8'hFF, 23'd0};
      if (e == 8'd0)   return {4'b0001, a[31], 31'd0};
      return {4'b0000, a[31], e + 8'd1, a[22:0]};
    end
    return '0;
  endfunction

  logic [W+3:0] pipe [0:LAT-1] = '{default: '0};
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= fmul_model(bus.mul_dataa, bus.mul_datab);
  end
  assign bus.mul_result    = pipe[LAT-1][W-1:0];
  assign bus.mul_nan       = pipe[LAT-1][W+3];
  assign bus.mul_overflow  = pipe[LAT-1][W+2];
  assign bus.mul_underflow = pipe[LAT-1][W+1];
  assign bus.mul_zero      = pipe[LAT-1][W];

  // Edge counter and delivery monitor
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          edge_no;
    logic        id;
    logic [31:0] data;
    logic        idle;
  } deliv_t;
  deliv_t dq[$];
  int both_high = 0;

  always @(negedge clk) begin
    if (bus.r0_valid || bus.r1_valid)
      dq.push_back('{edge_cnt, bus.r1_valid, bus.res_data, bus.idle});
    if (bus.r0_valid && bus.r1_valid) both_high <= both_high + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, output int acc_edge);
    if (!id) begin
      bus.a0_valid = 1'b1; bus.a0_dataa = a; bus.a0_datab = b;
    end else begin
      bus.a1_valid = 1'b1; bus.a1_dataa = a; bus.a1_datab = b;
    end
    #1;
    chk(id ? "a1_ready" : "a0_ready", id ? bus.a1_ready : bus.a0_ready, 1);
    acc_edge = edge_cnt + 1;
    step();
    bus.a0_valid = 1'b0;
    bus.a1_valid = 1'b0;
  endtask

  task automatic wait_deliv(input int n, input int budget);
    int k = 0;
    while (dq.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("deliv_count", dq.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ca0 [4];
    logic [31:0] ca1 [4];
    bit          cg  [4];
    logic [31:0] cres[4];
    int e;
    int s_edge;
    logic [31:0] sv;

    ca0  = '{F_2P0, F_1P5, F_1P5, F_8P0};
    ca1  = '{F_3P0, F_3P0, F_0P5, F_0P5};
    cg   = '{1'b0, 1'b1, 1'b0, 1'b1};
    cres = '{F_4P0, F_6P0, F_3P0, F_1P0};

    bus.a0_valid = 0; bus.a0_dataa = 0; bus.a0_datab = 0;
    bus.a1_valid = 0; bus.a1_dataa = 0; bus.a1_datab = 0;
    bus.stat_clr = 0;

    // ---- reset state ----
    repeat (2) step();
    bus.a0_valid = 1'b1;
    #1;
    chk("rst_a0_ready", bus.a0_ready, 0);
    bus.a0_valid = 1'b0;
    #1;
    chk("rst_mul_dataa", bus.mul_dataa, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_r0_valid", bus.r0_valid, 0);
    chk("rst_stat0", bus.stat0, 0);
    chk("rst_idle", bus.idle, 1);
    reset_n = 1'b1;
    step();

    // ---- contention: grants 0,1,0,1 ----
    dq.delete();
    s_edge = edge_cnt + 1;
    for (int i = 0; i < 4; i++) begin
      bus.a0_valid = 1'b1; bus.a0_dataa = ca0[i]; bus.a0_datab = F_2P0;
      bus.a1_valid = 1'b1; bus.a1_dataa = ca1[i]; bus.a1_datab = F_2P0;
      #1;
      chk($sformatf("cont_a0_ready%0d", i), bus.a0_ready, !cg[i]);
      chk($sformatf("cont_a1_ready%0d", i), bus.a1_ready, cg[i]);
      step();
    end
    bus.a0_valid = 1'b0;
    bus.a1_valid = 1'b0;
    wait_deliv(4, 30);
    for (int i = 0; i < 4 && i < dq.size(); i++) begin
      chk($sformatf("cont_id%0d", i), dq[i].id, cg[i]);
      chk($sformatf("cont_data%0d", i), dq[i].data, cres[i]);
      chk($sformatf("cont_edge%0d", i), dq[i].edge_no, s_edge + i + LAT + 1);
    end

    // ---- single a0 pair ----
    dq.delete();
    issue(0, F_1P0, F_2P0, e);
    chk("single_mul_dataa", bus.mul_dataa, F_1P0);
    chk("single_mul_datab", bus.mul_datab, F_2P0);
    step();
    chk("hold_mul_dataa", bus.mul_dataa, F_1P0);
    wait_deliv(1, 20);
    if (dq.size() >= 1) begin
      chk("single_edge", dq[0].edge_no, e + LAT + 1);
      chk("single_id", dq[0].id, 0);
      chk("single_data", dq[0].data, F_2P0);
    end
    repeat (3) step();
    chk("single_only_one", dq.size(), 1);
    chk("single_stat0", bus.stat0, 0);
    // rr now points at requester 1: a contended cycle must grant a1
    bus.a0_valid = 1'b1; bus.a1_valid = 1'b1;
    #1;
    chk("rr_a1_ready", bus.a1_ready, 1);
    chk("rr_a0_ready", bus.a0_ready, 0);
    bus.a0_valid = 1'b0; bus.a1_valid = 1'b0;
    step();

    // ---- streaming a1 for 20 cycles ----
    dq.delete();
    s_edge = edge_cnt + 1;
    for (int i = 0; i < 20; i++) begin
      bus.a1_valid = 1'b1;
      bus.a1_dataa = F_1P0;
      bus.a1_datab = {1'b0, 8'(128 + i), 23'd0};
      #1;
      chk($sformatf("stream_ready%0d", i), bus.a1_ready, 1);
      step();
    end
    bus.a1_valid = 1'b0;
    wait_deliv(20, 30);
    for (int i = 0; i < 20 && i < dq.size(); i++) begin
      sv = {1'b0, 8'(128 + i), 23'd0};
      chk($sformatf("stream_id%0d", i), dq[i].id, 1);
      chk($sformatf("stream_data%0d", i), dq[i].data, sv);
      chk($sformatf("stream_edge%0d", i), dq[i].edge_no, s_edge + i + LAT + 1);
      chk($sformatf("stream_idle%0d", i), dq[i].idle, (i == 19));
    end

    // ---- overflow flag, set wins over clear ----
    dq.delete();
    issue(0, F_MAX, F_2P0, e);
    wait_deliv(1, 20);
    if (dq.size() >= 1) chk("ovf_data", dq[0].data, F_INF);
    chk("ovf_stat0", bus.stat0, 4'b0100);
    chk("ovf_stat1", bus.stat1, 4'b0000);
    issue(0, F_MAX, F_2P0, e);
    repeat (LAT) step();
    bus.stat_clr = 1'b1;
    step();
    bus.stat_clr = 1'b0;
    chk("setwins_r0_valid", bus.r0_valid, 1);
    chk("setwins_stat0", bus.stat0, 4'b0100);

    // ---- reset mid-operation ----
    dq.delete();
    issue(0, F_1P0, F_2P0, e);
    issue(0, F_1P0, F_4P0, e);
    issue(0, F_1P0, F_8P0, e);
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_mul_dataa", bus.mul_dataa, 0);
    chk("midrst_mul_datab", bus.mul_datab, 0);
    chk("midrst_res_data", bus.res_data, 0);
    chk("midrst_stat0", bus.stat0, 0);
    step();
    reset_n = 1'b1;
    repeat (20) step();
    chk("midrst_no_deliv", dq.size(), 0);
    chk("midrst_idle", bus.idle, 1);
    chk("midrst_res_data_after", bus.res_data, 0);

    // ---- clear alone ----
    dq.delete();
    issue(0, F_MAX, F_2P0, e);
    wait_deliv(1, 20);
    chk("clr_pre_stat0", bus.stat0, 4'b0100);
    bus.stat_clr = 1'b1;
    step();
    bus.stat_clr = 1'b0;
    chk("clr_stat0", bus.stat0, 0);
    chk("clr_stat1", bus.stat1, 0);

    chk("never_both_valid", both_high, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
